// File: rtl/pkt_tx_peri_if.sv
// Register bus between a host and the packet transmit peripheral.
// The host drives one-cycle read/write strobes. The peripheral returns an
// acknowledge one cycle later, with read data in that same cycle.
interface pkt_tx_peri_if;
    logic [31:0] addr_32b_i;
    logic        wren_i;
    logic        rden_i;
    logic [31:0] din_32b_i;
    logic [31:0] dout_32b_o;
    logic        dout_32b_valid_o;

    modport master (
        output addr_32b_i, wren_i, rden_i, din_32b_i,
        input  dout_32b_o, dout_32b_valid_o
    );

    modport slave (
        input  addr_32b_i, wren_i, rden_i, din_32b_i,
        output dout_32b_o, dout_32b_valid_o
    );
endinterface

// File: rtl/pkt_tx_peri.sv
// Packet transmit peripheral.
// The host stages 32-bit words into a buffer through the DATA register, then
// writes GO. The block streams the words as 134-bit flits, four words per
// flit, with a head/body/tail tag and an invalid-byte count on the tail.
// STATUS reports done/busy/full/err and the staged word count. The done
// flag can raise a level interrupt.
module pkt_tx_peri #(
    parameter int BUF_WORDS = 64
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    pkt_tx_peri_if.slave   bus,
    output logic           interrupt_o,
    output logic           data_out_valid,
    output logic [133:0]   data_out
);
    localparam int CW = $clog2(BUF_WORDS + 1);  // count width, holds BUF_WORDS
    localparam int AW = $clog2(BUF_WORDS);      // buffer word address
    localparam int FW = AW - 2;                 // flit index

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [31:0]   buf_mem [BUF_WORDS];
    logic [CW-1:0] count_q;
    logic [FW-1:0] flit_q;
    logic          err_q, done_q, irq_en_q;

    logic [1:0]    reg_sel;
    logic          wr_data, wr_ctrl, wr_stat, wr_irqen;
    logic          idle, full, go_req, go_ok, go_bad, clear;
    logic          data_ok, data_drop, last_flit, tail_now;
    logic          done_d, irq_en_d;
    logic [CW-1:0] nflits;
    logic [7:0]    cnt8;
    logic [31:0]   status, rd_mux;
    logic [133:0]  flit_d;
    logic          unused_ok;

    // Register decode. Only address bits [3:2] select a register.
    assign reg_sel   = bus.addr_32b_i[3:2];
    assign wr_data   = bus.wren_i && (reg_sel == 2'd0);
    assign wr_ctrl   = bus.wren_i && (reg_sel == 2'd1);
    assign wr_stat   = bus.wren_i && (reg_sel == 2'd2);
    assign wr_irqen  = bus.wren_i && (reg_sel == 2'd3);

    assign idle      = (state_q == IDLE);
    assign full      = (count_q == CW'(BUF_WORDS));
    // CLEAR (bit1) overrides GO (bit0) when both are set in the same write.
    assign clear     = wr_ctrl && bus.din_32b_i[1] && idle;
    assign go_req    = wr_ctrl && bus.din_32b_i[0] && !bus.din_32b_i[1] && idle;
    assign go_ok     = go_req && (count_q >= CW'(8));
    assign go_bad    = go_req && (count_q <  CW'(8));
    assign data_ok   = wr_data && idle && !full;
    assign data_drop = wr_data && !data_ok;

    // Flit count is ceil(count/4). The count is frozen while sending.
    assign nflits    = (count_q + CW'(3)) >> 2;
    assign last_flit = (CW'(flit_q) == nflits - CW'(1));
    assign tail_now  = (state_q == SEND) && last_flit;

    // If the tail sets done in the same cycle as a W1C write, done stays set.
    assign done_d    = tail_now || (done_q && !(wr_stat && bus.din_32b_i[0]));
    assign irq_en_d  = wr_irqen ? bus.din_32b_i[0] : irq_en_q;

    assign cnt8      = 8'(count_q);
    assign status    = {16'b0, cnt8, 4'b0, err_q, full, (state_q == SEND), done_q};

    assign unused_ok = ^{bus.addr_32b_i[31:4], bus.addr_32b_i[1:0],
                         bus.din_32b_i[31:4], bus.din_32b_i[2]};

    // Read mux. Write-only registers read back as zero.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd2:    rd_mux = status;
            2'd3:    rd_mux = {31'b0, irq_en_q};
            default: rd_mux = '0;
        endcase
    end

    // Build the current flit. Lane 0 goes to the top word. Lanes past the
    // staged count read as zero.
    always_comb begin
        flit_d = '0;
        for (int j = 0; j < 4; j++) begin
            if (CW'({flit_q, 2'(j)}) < count_q)
                flit_d[127-32*j -: 32] = buf_mem[{flit_q, 2'(j)}];
        end
        if (flit_q == '0)
            flit_d[133:132] = 2'b01;
        else if (last_flit)
            flit_d[133:132] = 2'b10;
        if (last_flit)
            flit_d[131:128] = {2'(3'd4 - {1'b0, count_q[1:0]}), 2'b00};
    end

    // Next state: IDLE to SEND on an accepted GO, back to IDLE after the tail.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_ok) state_d = SEND;
            SEND:    if (last_flit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Staging buffer. Not reset: its contents outlive a send; only count restarts.
    always_ff @(posedge clk_i) begin
        if (data_ok) buf_mem[count_q[AW-1:0]] <= bus.din_32b_i;
    end

    // Control and status flags, word count, flit index and interrupt.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            flit_q      <= '0;
            interrupt_o <= 1'b0;
        end else begin
            if (tail_now || clear) count_q <= '0;
            else if (data_ok)      count_q <= count_q + CW'(1);

            if (data_drop || go_bad)                        err_q <= 1'b1;
            else if (clear || (wr_stat && bus.din_32b_i[3])) err_q <= 1'b0;

            done_q      <= done_d;
            irq_en_q    <= irq_en_d;
            interrupt_o <= done_d && irq_en_d;

            if ((state_q == SEND) && !last_flit) flit_q <= flit_q + FW'(1);
            else                                 flit_q <= '0;
        end
    end

    // Registered flit output, forced to zero whenever no flit is being sent.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else begin
            data_out_valid <= (state_q == SEND);
            data_out       <= (state_q == SEND) ? flit_d : '0;
        end
    end

    // Bus acknowledge with read data one cycle after every strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.dout_32b_valid_o <= 1'b0;
            bus.dout_32b_o       <= '0;
        end else begin
            bus.dout_32b_valid_o <= bus.wren_i || bus.rden_i;
            bus.dout_32b_o       <= bus.rden_i ? rd_mux : '0;
        end
    end
endmodule

// File: tb/tb_pkt_tx_peri.sv
// Bench for pkt_tx_peri. It applies a table of register vectors, then runs
// hand sequences for sends, buffer full, interrupt and mid-packet reset.
// Expected flits are built from a word-level model and queued. A monitor
// pops and compares them as the DUT emits flits.
module tb_pkt_tx_peri;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         interrupt;
    logic         dvalid;
    logic [133:0] dout;

    pkt_tx_peri_if bif();

    pkt_tx_peri #(.BUF_WORDS(64)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .bus            (bif),
        .interrupt_o    (interrupt),
        .data_out_valid (dvalid),
        .data_out       (dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [133:0] exp_q[$];
    logic [31:0]  mem [64];
    int           mcnt = 0;
    logic         prev_v = 1'b0;
    logic [1:0]   prev_tag = 2'b00;
    vec_t         tbl[$];

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Flit monitor and scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v <= 1'b0;
        end else begin
            if (dvalid) begin
                if (!prev_v) chk("head_tag", 134'(dout[133:132]), 134'(2'b01));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_flit: got %h expected none", dout);
                end else begin
                    chk("flit", dout, exp_q.pop_front());
                end
            end else begin
                chk("idle_data", dout, '0);
                if (prev_v) chk("tail_before_gap", 134'(prev_tag), 134'(2'b10));
            end
            prev_v   <= dvalid;
            prev_tag <= dout[133:132];
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        r = $urandom();
        bif.addr_32b_i = {r[31:4], a, r[1:0]};
        bif.din_32b_i  = d;
        bif.wren_i     = 1'b1;
        @(negedge clk);
        bif.wren_i = 1'b0;
        chk("wr_ack", 134'(bif.dout_32b_valid_o), 134'(1));
        chk("wr_rdata", 134'(bif.dout_32b_o), '0);
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] e);
        logic [31:0] r;
        r = $urandom();
        bif.addr_32b_i = {r[31:4], a, r[1:0]};
        bif.rden_i     = 1'b1;
        @(negedge clk);
        bif.rden_i = 1'b0;
        chk("rd_ack", 134'(bif.dout_32b_valid_o), 134'(1));
        chk(nm, 134'(bif.dout_32b_o), 134'(e));
    endtask

    task automatic put_word(input logic [31:0] d);
        bus_wr(2'd0, d);
        if (mcnt < 64) begin
            mem[mcnt] = d;
            mcnt++;
        end
    endtask

    // Queue the flits the staged words should produce, then write GO.
    task automatic go();
        int n;
        logic [133:0] e;
        n = (mcnt + 3) / 4;
        for (int f = 0; f < n; f++) begin
            e = '0;
            for (int j = 0; j < 4; j++)
                if (4*f + j < mcnt) e[127-32*j -: 32] = mem[4*f + j];
            e[133:132] = (f == 0) ? 2'b01 : ((f == n-1) ? 2'b10 : 2'b00);
            if (f == n-1) e[131:128] = 4'(4 * ((4 - mcnt % 4) % 4));
            exp_q.push_back(e);
        end
        mcnt = 0;
        bus_wr(2'd1, 32'h1);
    endtask

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(nm, 134'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bif.addr_32b_i = '0;
        bif.wren_i     = 1'b0;
        bif.rden_i     = 1'b0;
        bif.din_32b_i  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_valid", 134'(dvalid), '0);
        chk("rst_data", dout, '0);
        chk("rst_irq", 134'(interrupt), '0);
        chk("rst_ack", 134'(bif.dout_32b_valid_o), '0);
        chk("rst_rdata", 134'(bif.dout_32b_o), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Register vectors.
        tbl.push_back('{1'b0, 2'd2, 32'h0, 32'h0000_0000});
        tbl.push_back('{1'b0, 2'd3, 32'h0, 32'h0000_0000});
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 2'd0, 32'h11 + 32'(i), 32'h0});
        tbl.push_back('{1'b0, 2'd2, 32'h0, 32'h0000_0500});
        tbl.push_back('{1'b0, 2'd0, 32'h0, 32'h0000_0000});
        tbl.push_back('{1'b0, 2'd1, 32'h0, 32'h0000_0000});
        tbl.push_back('{1'b1, 2'd1, 32'h1, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 32'h0, 32'h0000_0508});
        tbl.push_back('{1'b1, 2'd2, 32'h8, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 32'h0, 32'h0000_0500});
        tbl.push_back('{1'b1, 2'd1, 32'h1, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 32'h0, 32'h0000_0508});
        tbl.push_back('{1'b1, 2'd1, 32'h3, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 32'h0, 32'h0000_0000});
        tbl.push_back('{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b0, 2'd3, 32'h0, 32'h0000_0001});
        tbl.push_back('{1'b1, 2'd3, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 2'd3, 32'h0, 32'h0000_0000});
        tbl.push_back('{1'b1, 2'd1, 32'h1, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 32'h0, 32'h0000_0008});
        tbl.push_back('{1'b1, 2'd1, 32'h2, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 32'h0, 32'h0000_0000});
        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                bus_wr(tbl[i].a, tbl[i].d);
                if (tbl[i].a == 2'd0 && mcnt < 64) begin mem[mcnt] = tbl[i].d; mcnt++; end
                if (tbl[i].a == 2'd1 && tbl[i].d[1]) mcnt = 0;
            end else begin
                rd_chk($sformatf("vec%0d", i), tbl[i].a, tbl[i].exp);
            end
        end

        // Eight words, two flits, first flit two cycles after GO.
        for (int i = 0; i < 8; i++) put_word(32'(i));
        go();
        chk("go_lat_c1", 134'(dvalid), '0);
        @(negedge clk);
        chk("go_lat_c2", 134'(dvalid), 134'(1));
        wait_drain("drain8");
        rd_chk("status_done8", 2'd2, 32'h0000_0001);
        bus_wr(2'd2, 32'h1);
        rd_chk("status_w1c", 2'd2, 32'h0000_0000);

        // Ten words, partial tail. A DATA write during SEND is dropped.
        for (int i = 0; i < 10; i++) put_word(32'h100 + 32'(i));
        go();
        bus_wr(2'd0, 32'hDEAD_BEEF);
        wait_drain("drain10");
        rd_chk("status_done10", 2'd2, 32'h0000_0009);
        bus_wr(2'd2, 32'h9);
        rd_chk("status_clr10", 2'd2, 32'h0000_0000);

        // Fill the buffer, overflow by one word, then send 16 flits.
        for (int i = 0; i < 65; i++) put_word($urandom());
        rd_chk("status_full", 2'd2, 32'h0000_400C);
        bus_wr(2'd2, 32'h8);
        rd_chk("status_full_noerr", 2'd2, 32'h0000_4004);
        go();
        wait_drain("drain64");
        rd_chk("status_done64", 2'd2, 32'h0000_0001);
        bus_wr(2'd2, 32'h1);

        // Interrupt follows done when enabled; a W1C of done drops it.
        bus_wr(2'd3, 32'h1);
        chk("irq_idle", 134'(interrupt), '0);
        for (int i = 0; i < 8; i++) put_word(32'h20 + 32'(i));
        go();
        wait_drain("drain_irq");
        chk("irq_set", 134'(interrupt), 134'(1));
        bus_wr(2'd2, 32'h1);
        chk("irq_clr", 134'(interrupt), '0);
        rd_chk("status_irq", 2'd2, 32'h0000_0000);

        // Reset while the third of 16 flits is on the output.
        for (int i = 0; i < 64; i++) put_word(32'h3000 + 32'(i));
        go();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 134'(dvalid), '0);
        chk("abort_data", dout, '0);
        exp_q.delete();
        mcnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("status_post_rst", 2'd2, 32'h0000_0000);
        rd_chk("irqen_post_rst", 2'd3, 32'h0000_0000);
        repeat (20) @(negedge clk);

        // A normal send after the reset.
        for (int i = 0; i < 9; i++) put_word(32'h500 + 32'(i));
        go();
        wait_drain("drain_post_rst");
        rd_chk("status_post_send", 2'd2, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pkt_tx_peri.md
PKT_TX_PERI -- requirements
Module: pkt_tx_peri

Interface
REQ-001 SHALL have parameter BUF_WORDS, default 64, meaning staging buffer depth in 32-bit words (multiple of 4, 16 flits).
REQ-002 SHALL have ports clk_i input 1, rising-edge clock; rst_n_i input 1, asynchronous active-low reset.
REQ-003 SHALL have addr_32b_i input 32, register address from bus; only bits [3:2] decoded.
REQ-004 SHALL have wren_i input 1 (write strobe) and rden_i input 1 (read strobe), each one-cycle pulse.
REQ-005 SHALL have din_32b_i input 32, write data.
REQ-006 SHALL have dout_32b_o output 32 (read data) and dout_32b_valid_o output 1 (access acknowledge).
REQ-007 SHALL have interrupt_o output 1, level interrupt.
REQ-008 SHALL have data_out_valid output 1 and data_out output 134, packet flit stream, no backpressure.

Function
REQ-009 SHALL decode registers: 0 DATA (W), 1 CTRL (W), 2 STATUS (R, W1C), 3 IRQ_EN (R/W, bit0).
REQ-010 SHALL pulse dout_32b_valid_o exactly one cycle after every wren_i or rden_i, any address; dout_32b_o holds read data in that cycle, 0 for write-only registers.
REQ-011 DATA write in IDLE with count < BUF_WORDS SHALL store word k=count at flit k/4, lane k%4 (lane 0 at data bits [127:96]), then count++.
REQ-012 DATA write while SEND or with count == BUF_WORDS SHALL be dropped and set STATUS.err.
REQ-013 CTRL write bit1 (CLEAR) in IDLE SHALL zero count and err; bit1 wins over bit0 in same write; CLEAR while SEND ignored.
REQ-014 CTRL write bit0 (GO) in IDLE with count >= 8 SHALL enter SEND next cycle; with count < 8 SHALL set err and stay IDLE.
REQ-015 STATUS read SHALL return {16'b0, count[7:0], 4'b0, err, full, busy, done} bits [3:0]=done,busy,full,err... precisely: bit0 done, bit1 busy, bit2 full, bit3 err, bits[15:8] count.
REQ-016 State machine: IDLE -> SEND (on valid GO); SEND -> IDLE after tail flit, setting done and zeroing count.
REQ-017 In SEND SHALL emit one flit per cycle, data_out_valid=1, flits 0..N-1, N=ceil(count/4), no gaps.
REQ-018 data_out[133:132] SHALL be 01 first flit, 10 last flit, 00 otherwise; data_out[127:0] flit payload.
REQ-019 data_out[131:128] SHALL be 0 except on tail: number of invalid bytes = 4*((4-count%4)%4); unused tail lanes output 0.
REQ-020 First flit SHALL appear 2 cycles after GO write cycle (1 cycle decode, 1 cycle registered output); data_out_valid=0 and data_out=0 when not emitting.
REQ-021 STATUS write with bit0=1 SHALL clear done (W1C), bit3=1 SHALL clear err; clear and set same cycle: set wins.
REQ-022 interrupt_o SHALL equal done & IRQ_EN[0], registered.
REQ-023 Buffer contents SHALL persist after send; only count reset.

Reset
REQ-024 rst_n_i low SHALL asynchronously force IDLE, count=0, done=0, err=0, IRQ_EN=0, all outputs 0; buffer contents need not reset.
REQ-025 Reset mid-SEND SHALL abort packet immediately with no tail flit; first post-reset flit only after new GO.

Verification
REQ-026 Write 8 DATA words 0x00..0x07, GO -> 2 flits: head {01,0,0x00000000_00000001_00000002_00000003}, tail {10,0,0x4..0x7}; done=1.
REQ-027 Write 10 words, GO -> 3 flits; tail tag 10, [131:128]=8, lanes 2,3 = 0; STATUS after = 0x0000_0001.
REQ-028 Write 5 words, GO -> no output, STATUS.err=1, count=5; CLEAR -> STATUS=0.
REQ-029 Fill 64 words, 65th write -> dropped, full=1, err=1; GO -> 16 flits contiguous, head/14 body/tail.
REQ-030 IRQ_EN=1, send 8 words -> interrupt_o=1 after tail; STATUS write 0x1 -> interrupt_o=0 next cycle.
REQ-031 Assert rst_n_i during flit 3 of 16 -> data_out_valid=0 immediately, STATUS=0 after reset release.
